decode_stage: RTL and testbench

//  ID pipeline stage of the pinca-puca MIPS32 core. Decodes the instruction from IF and drives the

---
 rtl/decode_stage_pkg.sv | 43 ++++
 rtl/decode_stage_instr_decoder.sv | 72 +++++++
 rtl/decode_stage.sv | 158 +++++++++++++++
 tb/tb_decode_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct encodings, ALU op codes,
// and the control bundle carried through the ID/EX register.
package decode_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLT = 4'd4,
      ALU_LUI = 4'd5
   } aluop_e;

   typedef struct packed {
      aluop_e aluop;
      logic   alusrc;
      logic   memread;
      logic   memwrite;
      logic   regwrite;
      logic   branch;
      logic   bne;
      logic   jump;
      logic   illegal;
   } ctrl_t;

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational MIPS32 subset decoder: instruction word -> control, destination, immediate.
module decode_stage_instr_decoder
   import decode_stage_pkg::*;
(
   input  logic [31:0] instr_i,
   output ctrl_t       ctrl_o,
   output logic [4:0]  dest_o,
   output logic [31:0] imm_o,
   output logic        uses_rt_o
);

   logic [5:0]  op, funct;
   logic [4:0]  rt, rd;
   logic [31:0] sext, zext;

   assign op    = instr_i[31:26];
   assign rt    = instr_i[20:16];
   assign rd    = instr_i[15:11];
   assign funct = instr_i[5:0];
   assign sext  = {{16{instr_i[15]}}, instr_i[15:0]};
   assign zext  = {16'h0, instr_i[15:0]};

   always_comb begin
      ctrl_o    = '0;
      dest_o    = '0;
      imm_o     = '0;
      uses_rt_o = 1'b0;
      case (op)
         OP_RTYPE: begin
            uses_rt_o = 1'b1;
            case (funct)
               FN_ADD:  ctrl_o.aluop = ALU_ADD;
               FN_SUB:  ctrl_o.aluop = ALU_SUB;
               FN_AND:  ctrl_o.aluop = ALU_AND;
               FN_OR:   ctrl_o.aluop = ALU_OR;
               FN_SLT:  ctrl_o.aluop = ALU_SLT;
               default: ctrl_o.illegal = 1'b1;
            endcase
            if (!ctrl_o.illegal) dest_o = rd;
         end
         OP_ADDI: begin ctrl_o.alusrc = 1'b1; dest_o = rt; imm_o = sext; end
         OP_ANDI: begin ctrl_o.aluop = ALU_AND; ctrl_o.alusrc = 1'b1; dest_o = rt; imm_o = zext; end
         OP_ORI:  begin ctrl_o.aluop = ALU_OR;  ctrl_o.alusrc = 1'b1; dest_o = rt; imm_o = zext; end
         OP_LUI:  begin
            ctrl_o.aluop  = ALU_LUI;
            ctrl_o.alusrc = 1'b1;
            dest_o        = rt;
            imm_o         = {instr_i[15:0], 16'h0};
         end
         OP_LW: begin ctrl_o.alusrc = 1'b1; ctrl_o.memread = 1'b1; dest_o = rt; imm_o = sext; end
         OP_SW: begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.memwrite = 1'b1;
            imm_o           = sext;
            uses_rt_o       = 1'b1;
         end
         // Branches compare rs/rt in the ALU, so they subtract.
         OP_BEQ: begin ctrl_o.aluop = ALU_SUB; ctrl_o.branch = 1'b1; imm_o = sext; uses_rt_o = 1'b1; end
         OP_BNE: begin
            ctrl_o.aluop  = ALU_SUB;
            ctrl_o.branch = 1'b1;
            ctrl_o.bne    = 1'b1;
            imm_o         = sext;
            uses_rt_o     = 1'b1;
         end
         OP_J:    begin ctrl_o.jump = 1'b1; imm_o = {6'h0, instr_i[25:0]}; end
         default: ctrl_o.illegal = 1'b1;
      endcase
      ctrl_o.regwrite = (dest_o != 5'd0);
   end

endmodule

// File: rtl/decode_stage.sv
// ID stage: register-port addressing, writeback bypass, load-use hazard detection and
// the ID/EX pipeline register with flush/stall handling.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_valid,
   input  logic [31:0]           if_instr,
   input  logic [31:0]           if_pc,
   output logic                  if_ready,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] dataa,
   input  logic [DATA_WIDTH-1:0] datab,
   input  logic                  enc,
   input  logic [ADDR_WIDTH-1:0] addrc,
   input  logic [DATA_WIDTH-1:0] datac,
   input  logic                  flush,
   input  logic                  ex_stall,
   output logic                  ex_valid,
   output logic [31:0]           ex_pc,
   output logic [DATA_WIDTH-1:0] ex_rs_data,
   output logic [DATA_WIDTH-1:0] ex_rt_data,
   output logic [ADDR_WIDTH-1:0] ex_rs,
   output logic [ADDR_WIDTH-1:0] ex_rt,
   output logic [ADDR_WIDTH-1:0] ex_dest,
   output logic [31:0]           ex_imm,
   output logic [3:0]            ex_aluop,
   output logic                  ex_alusrc,
   output logic                  ex_memread,
   output logic                  ex_memwrite,
   output logic                  ex_regwrite,
   output logic                  ex_branch,
   output logic                  ex_bne,
   output logic                  ex_jump,
   output logic                  ex_illegal
);

   ctrl_t                 dec_ctrl;
   logic [4:0]            dec_dest;
   logic [31:0]           dec_imm;
   logic                  dec_uses_rt;
   logic [ADDR_WIDTH-1:0] rs, rt;
   logic [DATA_WIDTH-1:0] rs_fwd, rt_fwd;
   logic                  hazard;

   logic                  valid_q, valid_d;
   ctrl_t                 ctrl_q, ctrl_d;
   logic [31:0]           pc_q, pc_d, imm_q, imm_d;
   logic [DATA_WIDTH-1:0] rsd_q, rsd_d, rtd_q, rtd_d;
   logic [ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;

   decode_stage_instr_decoder u_dec (
      .instr_i   (if_instr),
      .ctrl_o    (dec_ctrl),
      .dest_o    (dec_dest),
      .imm_o     (dec_imm),
      .uses_rt_o (dec_uses_rt)
   );

   assign rs    = ADDR_WIDTH'(if_instr[25:21]);
   assign rt    = ADDR_WIDTH'(if_instr[20:16]);
   assign addra = rs;
   assign addrb = rt;

   // Registers commits at the same edge we sample, so a matching write must be bypassed.
   assign rs_fwd = (rs == '0) ? '0 : (enc && addrc == rs) ? datac : dataa;
   assign rt_fwd = (rt == '0) ? '0 : (enc && addrc == rt) ? datac : datab;

   assign hazard = valid_q && ctrl_q.memread && (dest_q != '0) &&
                   ((dest_q == rs) || (dec_uses_rt && dest_q == rt));

   assign if_ready = !reset && (flush || (!ex_stall && !hazard));

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      rsd_d   = rsd_q;
      rtd_d   = rtd_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      dest_d  = dest_q;
      if (flush || (!ex_stall && (hazard || !if_valid))) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         pc_d    = '0;
         imm_d   = '0;
         rsd_d   = '0;
         rtd_d   = '0;
         rs_d    = '0;
         rt_d    = '0;
         dest_d  = '0;
      end else if (ex_stall) begin
         // Keep held operands coherent with writebacks that land during the stall.
         if (enc && addrc != '0 && addrc == rs_q) rsd_d = datac;
         if (enc && addrc != '0 && addrc == rt_q) rtd_d = datac;
      end else begin
         valid_d = 1'b1;
         ctrl_d  = dec_ctrl;
         pc_d    = if_pc;
         imm_d   = dec_imm;
         rsd_d   = rs_fwd;
         rtd_d   = rt_fwd;
         rs_d    = rs;
         rt_d    = rt;
         dest_d  = ADDR_WIDTH'(dec_dest);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pc_q    <= '0;
         imm_q   <= '0;
         rsd_q   <= '0;
         rtd_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         dest_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         rsd_q   <= rsd_d;
         rtd_q   <= rtd_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         dest_q  <= dest_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_rs_data  = rsd_q;
   assign ex_rt_data  = rtd_q;
   assign ex_rs       = rs_q;
   assign ex_rt       = rt_q;
   assign ex_dest     = dest_q;
   assign ex_imm      = imm_q;
   assign ex_aluop    = ctrl_q.aluop;
   assign ex_alusrc   = ctrl_q.alusrc;
   assign ex_memread  = ctrl_q.memread;
   assign ex_memwrite = ctrl_q.memwrite;
   assign ex_regwrite = ctrl_q.regwrite;
   assign ex_branch   = ctrl_q.branch;
   assign ex_bne      = ctrl_q.bne;
   assign ex_jump     = ctrl_q.jump;
   assign ex_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then randomized traffic, all checked
// against a behavioural model of the ID/EX register and a model register file.
module tb_decode_stage;

   logic        clock, reset, if_valid, if_ready, enc, flush, ex_stall;
   logic [31:0] if_instr, if_pc, dataa, datab, datac;
   logic [4:0]  addra, addrb, addrc;
   logic        ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite;
   logic        ex_branch, ex_bne, ex_jump, ex_illegal;
   logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_dest;
   logic [3:0]  ex_aluop;

   decode_stage dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(if_ready), .addra(addra), .addrb(addrb), .dataa(dataa), .datab(datab),
      .enc(enc), .addrc(addrc), .datac(datac), .flush(flush), .ex_stall(ex_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_imm(ex_imm), .ex_aluop(ex_aluop),
      .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump),
      .ex_illegal(ex_illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      logic [31:0] pc, rsd, rtd, imm;
      logic [4:0]  rs, rt, dest;
      logic [3:0]  aluop;
      logic        alusrc, memread, memwrite, regwrite, branch, bne, jump, illegal;
   } ex_t;

   ex_t         m;
   logic [31:0] rf [32];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ex_t bubble();
      ex_t e;
      e = '{valid: 1'b0, pc: '0, rsd: '0, rtd: '0, imm: '0, rs: '0, rt: '0, dest: '0,
            aluop: '0, alusrc: 1'b0, memread: 1'b0, memwrite: 1'b0, regwrite: 1'b0,
            branch: 1'b0, bne: 1'b0, jump: 1'b0, illegal: 1'b0};
      return e;
   endfunction

   function automatic logic reads_rt(input logic [31:0] instr);
      logic [5:0] op;
      op = instr[31:26];
      return op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05;
   endfunction

   // Source operand as execute must see it: $0 is zero, a same-cycle write wins.
   function automatic logic [31:0] opnd(input logic [4:0] idx, input logic en,
                                        input logic [4:0] ac, input logic [31:0] dc);
      if (idx == 0) return 32'h0;
      if (en && ac == idx) return dc;
      return rf[idx];
   endfunction

   function automatic ex_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic en, input logic [4:0] ac, input logic [31:0] dc);
      ex_t        e;
      logic [5:0] op, fn;
      logic [31:0] se, ze;
      e = bubble();
      op = instr[31:26];
      fn = instr[5:0];
      se = 32'(signed'(instr[15:0]));
      ze = 32'(instr[15:0]);
      e.valid = 1'b1;
      e.pc = pc;
      e.rs = instr[25:21];
      e.rt = instr[20:16];
      e.rsd = opnd(e.rs, en, ac, dc);
      e.rtd = opnd(e.rt, en, ac, dc);
      case (op)
         6'h00: case (fn)
            6'h20: begin e.aluop = 0; e.dest = instr[15:11]; end
            6'h22: begin e.aluop = 1; e.dest = instr[15:11]; end
            6'h24: begin e.aluop = 2; e.dest = instr[15:11]; end
            6'h25: begin e.aluop = 3; e.dest = instr[15:11]; end
            6'h2A: begin e.aluop = 4; e.dest = instr[15:11]; end
            default: e.illegal = 1'b1;
         endcase
         6'h08: begin e.aluop = 0; e.alusrc = 1; e.imm = se; e.dest = e.rt; end
         6'h0C: begin e.aluop = 2; e.alusrc = 1; e.imm = ze; e.dest = e.rt; end
         6'h0D: begin e.aluop = 3; e.alusrc = 1; e.imm = ze; e.dest = e.rt; end
         6'h0F: begin e.aluop = 5; e.alusrc = 1; e.imm = ze << 16; e.dest = e.rt; end
         6'h23: begin e.aluop = 0; e.alusrc = 1; e.memread = 1; e.imm = se; e.dest = e.rt; end
         6'h2B: begin e.aluop = 0; e.alusrc = 1; e.memwrite = 1; e.imm = se; end
         6'h04: begin e.aluop = 1; e.branch = 1; e.imm = se; end
         6'h05: begin e.aluop = 1; e.branch = 1; e.bne = 1; e.imm = se; end
         6'h02: begin e.jump = 1; e.imm = {6'h0, instr[25:0]}; end
         default: e.illegal = 1'b1;
      endcase
      e.regwrite = (e.dest != 0);
      return e;
   endfunction

   // One clock: drive at negedge, check combinational outputs, advance model, check ID/EX.
   task automatic cycle(input logic rst, input logic v, input logic [31:0] instr,
                        input logic [31:0] pc, input logic en, input logic [4:0] ac,
                        input logic [31:0] dc, input logic fl, input logic st);
      logic haz, rdy;
      @(negedge clock);
      reset = rst; if_valid = v; if_instr = instr; if_pc = pc;
      enc = en; addrc = ac; datac = dc; flush = fl; ex_stall = st;
      dataa = rf[instr[25:21]];
      datab = rf[instr[20:16]];
      #1;
      haz = m.valid && m.memread && m.dest != 0 &&
            (m.dest == instr[25:21] || (reads_rt(instr) && m.dest == instr[20:16]));
      rdy = !rst && (fl || (!st && !haz));
      chk("if_ready", if_ready, rdy);
      chk("addra", addra, instr[25:21]);
      chk("addrb", addrb, instr[20:16]);
      if (rst || fl)  m = bubble();
      else if (st) begin
         if (en && ac != 0 && ac == m.rs) m.rsd = dc;
         if (en && ac != 0 && ac == m.rt) m.rtd = dc;
      end
      else if (haz)   m = bubble();
      else if (v)     m = ref_decode(instr, pc, en, ac, dc);
      else            m = bubble();
      if (!rst && en && ac != 0) rf[ac] = dc;
      @(posedge clock);
      #1;
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs_data", ex_rs_data, m.rsd);
      chk("ex_rt_data", ex_rt_data, m.rtd);
      chk("ex_rs", ex_rs, m.rs);
      chk("ex_rt", ex_rt, m.rt);
      chk("ex_dest", ex_dest, m.dest);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_aluop", ex_aluop, m.aluop);
      chk("ex_ctrl", {ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_branch, ex_bne,
                      ex_jump, ex_illegal},
          {m.alusrc, m.memread, m.memwrite, m.regwrite, m.branch, m.bne, m.jump, m.illegal});
   endtask

   initial begin
      logic [31:0] instr;
      logic [5:0]  ops [15];
      logic [5:0]  fns [6];
      ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B,
              6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
      m = bubble();
      // $0 reads back garbage from the model file so a missing zero-force shows up.
      rf[0] = 32'hDEAD_0000;
      for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + i;
      reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; enc = 1'b0;
      addrc = '0; datac = '0; flush = 1'b0; ex_stall = 1'b0; dataa = '0; datab = '0;

      // Reset held three cycles, then first free cycle accepts.
      repeat (3) cycle(1, 1, 32'h2005FFFD, 32'h4, 0, 0, 0, 0, 0);
      cycle(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
      chk("post_reset_valid", ex_valid, 1'b0);

      // ADDI $5,$0,-3
      cycle(0, 1, 32'h2005FFFD, 32'h104, 0, 0, 0, 0, 0);
      chk("addi_imm", ex_imm, 32'hFFFFFFFD);
      chk("addi_dest", ex_dest, 5'd5);
      chk("addi_ops", {ex_aluop, ex_alusrc, ex_regwrite}, {4'd0, 1'b1, 1'b1});

      // ADD $3,$1,$2 with same-cycle writeback of $1
      rf[1] = 32'd7;
      cycle(0, 1, 32'h00221820, 32'h108, 1, 5'd1, 32'd9, 0, 0);
      chk("bypass_rs", ex_rs_data, 32'd9);
      chk("bypass_rt", ex_rt_data, rf[2]);

      // Load-use: LW $4,0($1); ADD $6,$4,$4 -> exactly one bubble
      cycle(0, 1, 32'h8C240000, 32'h10C, 0, 0, 0, 0, 0);
      cycle(0, 1, 32'h00843020, 32'h110, 0, 0, 0, 0, 0);
      chk("loaduse_bubble", ex_valid, 1'b0);
      cycle(0, 1, 32'h00843020, 32'h110, 0, 0, 0, 0, 0);
      chk("loaduse_issue", {ex_valid, ex_dest}, {1'b1, 5'd6});

      // Stall three cycles while $1 is rewritten
      cycle(0, 1, 32'h00221820, 32'h114, 0, 0, 0, 0, 0);
      repeat (3) cycle(0, 1, 32'h342700F0, 32'h118, 1, 5'd1, 32'hAAAA5555, 0, 1);
      chk("stall_pc_held", ex_pc, 32'h114);
      chk("stall_rs_fresh", ex_rs_data, 32'hAAAA5555);

      // Flush beats stall
      cycle(0, 1, 32'h342700F0, 32'h11C, 0, 0, 0, 1, 1);
      chk("flush_valid", ex_valid, 1'b0);
      // Unknown opcode
      cycle(0, 1, 32'hFC000000, 32'h120, 0, 0, 0, 0, 0);
      chk("illegal_op", {ex_valid, ex_illegal, ex_regwrite}, {1'b1, 1'b1, 1'b0});
      // Write to $0 is never bypassed
      cycle(0, 1, 32'h00001820, 32'h124, 1, 5'd0, 32'h12345678, 0, 0);
      chk("zero_no_bypass", {ex_rs_data, ex_rt_data}, 64'h0);

      // Reset in the middle of a stall
      cycle(0, 1, 32'h8C240000, 32'h128, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h00843020, 32'h12C, 0, 0, 0, 0, 1);
      chk("reset_mid_stall", ex_valid, 1'b0);

      for (int n = 0; n < 600; n++) begin
         instr = $urandom;
         instr[31:26] = ops[$urandom_range(14, 0)];
         instr[25:21] = 5'($urandom_range(7, 0));
         instr[20:16] = 5'($urandom_range(7, 0));
         instr[15:11] = 5'($urandom_range(7, 0));
         instr[5:0]   = fns[$urandom_range(5, 0)];
         cycle(($urandom_range(49, 0) == 0), ($urandom_range(4, 0) != 0), instr, $urandom,
               $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), $urandom,
               ($urandom_range(9, 0) == 0), ($urandom_range(4, 0) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
